// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive-side checker for a VGA pin interface.
// Samples hsync/vsync and 2-bit red/green/blue on the pixel clock. It recovers
// line and frame timing and the active-window pixel position. It reports a
// per-frame pixel checksum and a timing lock flag.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   hsync/vsync  sync pins, polarity set by HSYNC_/VSYNC_ACTIVE_LOW
//   red/green/blue  2-bit colour pins
//   pixel_valid  x/y/pixel lie inside the active window
//   x, y         active column/row (0 outside the window)
//   pixel        {red,green,blue} for x/y (0 outside the window)
//   h_period     clocks between the last two hsync leading edges
//   v_lines      lines in the last complete frame
//   frame_sum    16-bit pixel checksum of the last complete frame
//   frame_done   one-cycle pulse when v_lines/frame_sum update
//   locked       line length and frame height stable over the last two frames
module vga_rx_monitor #(
  parameter int unsigned CW               = 11,
  parameter bit          HSYNC_ACTIVE_LOW = 1'b1,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned H_START          = 144,
  parameter int unsigned H_ACTIVE         = 640,
  parameter int unsigned V_START          = 35,
  parameter int unsigned V_ACTIVE         = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [1:0]    red,
  input  logic [1:0]    green,
  input  logic [1:0]    blue,
  output logic          pixel_valid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [5:0]    pixel,
  output logic [CW-1:0] h_period,
  output logic [CW-1:0] v_lines,
  output logic [15:0]   frame_sum,
  output logic          frame_done,
  output logic          locked
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_OFF   = CW'(H_START);
  localparam logic [CW-1:0] V_OFF   = CW'(V_START);

  // Sync inputs are normalised before registering so that the reset value
  // (0) is always the inactive level, whatever the pin polarity.
  logic          hs_a, vs_a, hs_a_prev, vs_a_prev;
  logic [5:0]    rgb_d1, rgb_d2;
  logic [CW-1:0] h_cnt, line_cnt;
  logic          h_seen, f_seen, vs_pend, h_stable;
  logic [15:0]   acc;

  logic          h_edge, v_edge, frame_edge, h_sat, in_win;
  logic [CW-1:0] h_cnt_inc, line_inc;

  always_comb begin
    h_edge     = hs_a & ~hs_a_prev;
    v_edge     = vs_a & ~vs_a_prev;
    // A vsync edge coinciding with the hsync edge belongs to that hsync edge.
    frame_edge = h_edge & (vs_pend | v_edge);
    h_cnt_inc  = h_cnt + 1'b1;
    line_inc   = line_cnt + 1'b1;
    // Flags drop as h_cnt arrives at (or sits at) its saturated value.
    h_sat      = !h_edge && (h_cnt >= CNT_MAX - 1'b1);
    in_win     = f_seen
              && (32'(h_cnt) >= H_START) && (32'(h_cnt) < H_START + H_ACTIVE)
              && (32'(line_cnt) >= V_START) && (32'(line_cnt) < V_START + V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_a        <= 1'b0;
      vs_a        <= 1'b0;
      hs_a_prev   <= 1'b0;
      vs_a_prev   <= 1'b0;
      rgb_d1      <= '0;
      rgb_d2      <= '0;
      h_cnt       <= '0;
      line_cnt    <= '0;
      h_seen      <= 1'b0;
      f_seen      <= 1'b0;
      vs_pend     <= 1'b0;
      h_stable    <= 1'b0;
      acc         <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel       <= '0;
      h_period    <= '0;
      v_lines     <= '0;
      frame_sum   <= '0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      hs_a       <= hsync ^ HSYNC_ACTIVE_LOW;
      vs_a       <= vsync ^ VSYNC_ACTIVE_LOW;
      hs_a_prev  <= hs_a;
      vs_a_prev  <= vs_a;
      rgb_d1     <= {red, green, blue};
      rgb_d2     <= rgb_d1;
      frame_done <= 1'b0;

      // rgb_d2 is aligned with h_cnt/line_cnt, giving two cycles pin-to-output.
      pixel_valid <= in_win;
      x           <= in_win ? h_cnt - H_OFF : '0;
      y           <= in_win ? line_cnt - V_OFF : '0;
      pixel       <= in_win ? rgb_d2 : '0;
      if (in_win) acc <= acc + 16'(rgb_d2);

      if (h_edge) begin
        h_cnt  <= '0;
        h_seen <= 1'b1;
        if (frame_edge) begin
          if (f_seen) begin
            v_lines    <= line_inc;
            frame_sum  <= acc;
            frame_done <= 1'b1;
            locked     <= (line_inc == v_lines) && h_stable;
          end
          line_cnt <= '0;
          acc      <= '0;
          vs_pend  <= 1'b0;
          f_seen   <= 1'b1;
          h_stable <= 1'b1;
        end else if (line_cnt != CNT_MAX) begin
          line_cnt <= line_inc;
        end
        // Placed after the frame-edge set so a changed last line still clears it.
        if (h_seen) begin
          h_period <= h_cnt_inc;
          if (h_cnt_inc != h_period) h_stable <= 1'b0;
        end
      end else begin
        if (v_edge) vs_pend <= 1'b1;
        if (h_cnt != CNT_MAX) h_cnt <= h_cnt_inc;
        if (h_sat) begin
          locked <= 1'b0;
          h_seen <= 1'b0;
          f_seen <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down timing: 60 clk/line
// (6 hsync), 40 lines/frame (2 vsync), window 40x30 at (12,4).
// Two instances run side by side: active-low syncs and active-high syncs,
// driven with mirrored sync pins, both checked against the same expectations.
module tb_vga_rx_monitor;
  localparam int unsigned CW = 11, H_START = 12, H_ACTIVE = 40, V_START = 4, V_ACTIVE = 30;
  localparam int unsigned HT = 60, HS_W = 6, VT = 40, VS_W = 2, STRETCH_VP = 20;
  // 40 columns summed 0..39 = 780 per line, x30 lines = 23400
  localparam logic [15:0] SUM_COL   = 16'h5B68;
  // 1200 pixels * 63 = 75600 mod 65536 = 10064
  localparam logic [15:0] SUM_CONST = 16'h2750;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    hs_pin, vs_pin;
  logic [5:0]    rgb;
  logic          pv[2], fdo[2], lko[2];
  logic [CW-1:0] xo[2], yo[2], hpo[2], vlo[2];
  logic [5:0]    pxo[2];
  logic [15:0]   fso[2];

  vga_rx_monitor #(.CW(CW), .HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1),
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE)) dut_low (
    .clk(clk), .rst(rst), .hsync(hs_pin[0]), .vsync(vs_pin[0]),
    .red(rgb[5:4]), .green(rgb[3:2]), .blue(rgb[1:0]),
    .pixel_valid(pv[0]), .x(xo[0]), .y(yo[0]), .pixel(pxo[0]), .h_period(hpo[0]),
    .v_lines(vlo[0]), .frame_sum(fso[0]), .frame_done(fdo[0]), .locked(lko[0]));

  vga_rx_monitor #(.CW(CW), .HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0),
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE)) dut_high (
    .clk(clk), .rst(rst), .hsync(hs_pin[1]), .vsync(vs_pin[1]),
    .red(rgb[5:4]), .green(rgb[3:2]), .blue(rgb[1:0]),
    .pixel_valid(pv[1]), .x(xo[1]), .y(yo[1]), .pixel(pxo[1]), .h_period(hpo[1]),
    .v_lines(vlo[1]), .frame_sum(fso[1]), .frame_done(fdo[1]), .locked(lko[1]));

  int unsigned   checks = 0, errors = 0;
  int unsigned   hp, vp, idle_left;
  bit            armed, stretch, mode, rst_req;
  logic [28:0]   q0, q1, q2;
  int unsigned   done_cnt[2], vcnt[2], lat_vcnt[2];
  logic [CW-1:0] lat_v[2], lat_hp[2];
  logic [15:0]   lat_sum[2];
  logic          lat_lk[2];
  bit            saw61[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                          input logic [31:0] exp);
    chk({tag, "_low"}, o0, exp);
    chk({tag, "_high"}, o1, exp);
  endtask

  // One pixel clock: drive the next generator position, then compare the
  // window outputs against the sample driven two clocks earlier.
  task automatic tick();
    bit            hs_act, vs_act, in_win;
    logic [28:0]   e;
    logic [CW-1:0] col, row;
    int unsigned   len;
    e = '0;
    if (rst_req) armed = 1'b0;
    if (idle_left > 0 && hp == 0 && vp == 0) begin
      hs_act = 1'b0;
      vs_act = 1'b0;
      rgb    = 6'h15;
      armed  = 1'b0;
      idle_left--;
    end else begin
      hs_act = (hp < HS_W);
      vs_act = (vp < VS_W);
      in_win = (hp >= H_START) && (hp < H_START + H_ACTIVE)
            && (vp >= V_START) && (vp < V_START + V_ACTIVE);
      col = CW'(hp - H_START);
      row = CW'(vp - V_START);
      rgb = in_win ? (mode ? col[5:0] : 6'h3F) : 6'h15;
      if (hp == 0 && vp == 0 && !rst_req) armed = 1'b1;
      if (armed && in_win) e = {1'b1, col, row, rgb};
      len = (stretch && vp == STRETCH_VP) ? HT + 1 : HT;
      hp++;
      if (hp == len) begin
        hp = 0;
        if (len != HT) stretch = 1'b0;
        vp = (vp == VT - 1) ? 0 : vp + 1;
      end
    end
    q2 = q1;
    q1 = q0;
    q0 = e;
    if (rst_req) begin
      q1 = '0;
      q2 = '0;
    end
    hs_pin = {hs_act, ~hs_act};
    vs_pin = {vs_act, ~vs_act};
    rst    = rst_req;
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("window_d%0d", d), {3'b0, pv[d], xo[d], yo[d], pxo[d]}, {3'b0, q2});
      if (pv[d]) vcnt[d]++;
      if (hpo[d] == CW'(HT + 1)) saw61[d] = 1'b1;
      if (fdo[d]) begin
        done_cnt[d]++;
        lat_v[d]    = vlo[d];
        lat_hp[d]   = hpo[d];
        lat_sum[d]  = fso[d];
        lat_lk[d]   = lko[d];
        lat_vcnt[d] = vcnt[d];
        vcnt[d]     = 0;
      end
    end
  endtask

  task automatic run_until_done(input int unsigned target);
    int unsigned n = 0;
    while (done_cnt[0] < target && n < 3000) begin
      tick();
      n++;
    end
    chk_both("done_count", done_cnt[0], done_cnt[1], target);
  endtask

  task automatic check_frame(input logic [15:0] sum, input logic lk);
    chk_both("v_lines", lat_v[0], lat_v[1], VT);
    chk_both("h_period", lat_hp[0], lat_hp[1], HT);
    chk_both("frame_sum", lat_sum[0], lat_sum[1], sum);
    chk_both("locked", lat_lk[0], lat_lk[1], lk);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1; hs_pin = 2'b01; vs_pin = 2'b01; rgb = '0;
    hp = 0; vp = 0; idle_left = 0;
    armed = 1'b0; stretch = 1'b0; mode = 1'b1; rst_req = 1'b0;
    q0 = '0; q1 = '0; q2 = '0;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; vcnt[d] = 0; lat_vcnt[d] = 0; saw61[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_both("rst_pixel_valid", pv[0], pv[1], 0);
    chk_both("rst_h_period", hpo[0], hpo[1], 0);
    chk_both("rst_v_lines", vlo[0], vlo[1], 0);
    chk_both("rst_frame_sum", fso[0], fso[1], 0);
    chk_both("rst_locked", lko[0], lko[1], 0);

    // Frame 1 (column pattern): first report, no previous height to lock to.
    run_until_done(1);
    check_frame(SUM_COL, 1'b0);
    chk_both("valid_count1", lat_vcnt[0], lat_vcnt[1], H_ACTIVE * V_ACTIVE);
    mode = 1'b0;

    // Frame 2 constant 3F: checksum wraps modulo 2^16, timing now locked.
    run_until_done(2);
    check_frame(SUM_CONST, 1'b1);
    chk_both("valid_count2", lat_vcnt[0], lat_vcnt[1], H_ACTIVE * V_ACTIVE);
    mode = 1'b1;
    stretch = 1'b1;
    saw61[0] = 1'b0;
    saw61[1] = 1'b0;

    // Frame 3 has one 61-clock line: lock drops, then returns.
    run_until_done(3);
    check_frame(SUM_COL, 1'b0);
    chk_both("saw_h_period_61", saw61[0], saw61[1], 1);
    run_until_done(4);
    check_frame(SUM_COL, 1'b1);
    run_until_done(5);
    check_frame(SUM_COL, 1'b1);

    // hsync held inactive long enough to saturate h_cnt.
    idle_left = 2100;
    n = 0;
    while (idle_left > 0 && n < 6000) begin
      tick();
      n++;
    end
    chk("idle_finished", idle_left, 0);
    chk_both("sat_locked", lko[0], lko[1], 0);
    chk_both("sat_pixel_valid", pv[0], pv[1], 0);
    chk_both("sat_v_lines", vlo[0], vlo[1], VT);
    repeat (30) tick();
    chk_both("h_period_after_loss", hpo[0], hpo[1], HT);
    chk_both("locked_after_loss", lko[0], lko[1], 0);
    chk_both("no_report_after_loss", done_cnt[0], done_cnt[1], 5);
    run_until_done(6);
    check_frame(SUM_COL, 1'b1);

    // Reset mid-frame, inside the active window.
    repeat (500) tick();
    rst_req = 1'b1;
    tick();
    chk_both("mid_rst_pixel_valid", pv[0], pv[1], 0);
    chk_both("mid_rst_h_period", hpo[0], hpo[1], 0);
    chk_both("mid_rst_v_lines", vlo[0], vlo[1], 0);
    chk_both("mid_rst_frame_sum", fso[0], fso[1], 0);
    chk_both("mid_rst_frame_done", fdo[0], fdo[1], 0);
    chk_both("mid_rst_locked", lko[0], lko[1], 0);
    vcnt[0] = 0;
    vcnt[1] = 0;
    n = 0;
    while (!(vp == 0 && hp == 30) && n < 3000) begin
      tick();
      n++;
    end
    chk("reached_frame_start", n < 3000, 1);
    chk_both("first_vsync_v_lines", vlo[0], vlo[1], 0);
    chk_both("first_vsync_frame_sum", fso[0], fso[1], 0);
    chk_both("first_vsync_no_done", done_cnt[0], done_cnt[1], 6);
    run_until_done(7);
    check_frame(SUM_COL, 1'b0);
    chk_both("valid_count_after_rst", lat_vcnt[0], lat_vcnt[1], H_ACTIVE * V_ACTIVE);
    run_until_done(8);
    check_frame(SUM_COL, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
